mux_pipe_n: RTL and testbench
=============================

Name: mux_pipe_n

Overview:
- Parametrised successor to the combinational 4-way datapath mux: N-input selector with a registered output stage and valid/ready handshake.
- Used in the MIPS pipeline where a forwarding/result select must sit behind a pipeline register that honours stalls and flushes.
- Typical sites: EX result select and WB write-back select.
- Carries the selected index forward with the data and flags illegal selects.

Parameters:
- WIDTH, 32: data width per input.
- NUM_IN, 4: number of inputs, 2..16; need not be a power of two.
- SEL_W, $clog2(NUM_IN): select width. Derived; must not be overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  input index, sampled with the beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- flush  in  1  discard held and incoming beats (pipeline squash).
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  registered copy of sel for the held beat.
- sel_err  out  1  held beat had sel >= NUM_IN.
- out_valid  out  1  out_data/out_sel/sel_err are valid.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_sel=0, sel_err=0, skid empty. rst has priority over flush and all handshakes.
- Accept: in_valid && in_ready. Accepted beat appears on the outputs the next cycle (latency 1).
- Base mode (no skid): in_ready = !flush && (!out_valid || out_ready). This is a combinational path from out_ready.
- Output register loads on accept and captures:
  - out_data = in_data[sel];
  - out_sel = sel;
  - sel_err = (sel >= NUM_IN).
- On accept with illegal sel: out_data=0, sel_err=1, beat still delivered (valid).
- Hold: while out_valid && !out_ready, out_data, out_sel and sel_err are stable and in_ready=0.
- Drain: out_valid && out_ready && no accept -> out_valid=0 next cycle; out_data keeps its last value.
- Simultaneous drain+accept: new beat replaces old with no bubble (full throughput).
- Flush: next cycle out_valid=0 and skid emptied; in_ready=0 during flush, so no beat accepted that cycle. A flush coinciding with out_ready still drops the held beat; the downstream must ignore it.
- No internal FSM beyond the valid bit(s). State = {EMPTY, FULL} in base mode; {EMPTY, FULL, FULL+SKID} with the optional feature.

Optional Feature:
- Macro: MUX_PIPE_SKID_BUF_EN.
- Defined:
  - adds a one-entry skid register; in_ready is registered (= skid empty) and has no combinational path from out_ready;
  - a beat arriving while the output is held goes to skid;
  - on drain, skid moves to the output the same edge;
  - full throughput is preserved; flush clears both entries;
  - reset: skid valid=0, skid data=0.
- Undefined: base behaviour above with a combinational in_ready.

Decomposition:
- Shared package mips_pkg:
  - default DATA_W=32;
  - localparam function for select width;
  - sel_err encoding constant.
- Natural sub-module: mux_skid_buf (one-entry skid, WIDTH+SEL_W+1 payload), instantiated only under MUX_PIPE_SKID_BUF_EN.
- The mux itself stays inline as a for-loop compare.

Test Plan:
- Reset: WIDTH=32, NUM_IN=4, rst high 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_sel=0, sel_err=0 throughout; first accept only after rst drops.
- Basic select: inputs {0x33333333,0x22222222,0x11111111,0x00000000}, sel=2, in_valid=1, out_ready=1 -> next cycle out_data=0x22222222, out_sel=2, out_valid=1.
- Back-pressure: out_ready=0 for 3 cycles after a beat with sel=1 -> out_data holds 0x11111111, in_ready=0 (base mode). Raise out_ready with a new beat sel=3 -> 0x33333333 the next cycle, no bubble.
- Illegal select: NUM_IN=5, sel=3'd6 -> out_valid=1, out_data=0, sel_err=1; next legal beat sel=4 clears sel_err.
- Flush: beat held with out_ready=0, assert flush with in_valid=1 sel=0 -> in_ready=0 that cycle, out_valid=0 next cycle, incoming beat not captured.
- Skid (MUX_PIPE_SKID_BUF_EN): stream sel=0,1,2,3 with out_ready toggling 1,0,1,1 -> all four beats delivered in order, no loss or duplication; in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and helpers: default data width, select-width function
// and the sel_err encoding used by the pipelined selectors.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic SEL_ERR_ILLEGAL = 1'b1;
  localparam logic SEL_ERR_NONE    = 1'b0;

  // A single-input selector still needs a 1-bit select port to stay legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// One-entry skid register for mux_pipe_n; compiled only when MUX_PIPE_SKID_BUF_EN is defined.
// Holds one payload of {sel_err, sel, data} while the output stage is stalled.
`ifdef MUX_PIPE_SKID_BUF_EN
module mux_skid_buf #(
  parameter int P_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           load,
  input  logic [P_W-1:0] load_data,
  input  logic           unload,
  output logic           valid,
  output logic [P_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/mux_pipe_n.sv
// N-input selector behind a valid/ready output register, carrying sel and an illegal-select flag.
// Define MUX_PIPE_SKID_BUF_EN to add a skid entry and make in_ready a registered signal.
module mux_pipe_n
  import mips_pkg::*;
#(
  parameter  int WIDTH  = DATA_W,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int PL_W = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;
  logic [PL_W-1:0]  in_pl;
  logic [PL_W-1:0]  load_pl;
  logic             accept;
  logic             out_free;
  logic             load_out;

  // An out-of-range select matches no input, so the data falls through as zero.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign mux_err  = (32'(sel) >= NUM_IN) ? SEL_ERR_ILLEGAL : SEL_ERR_NONE;
  assign in_pl    = {mux_err, sel, mux_data};
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef MUX_PIPE_SKID_BUF_EN
  logic            skid_valid;
  logic [PL_W-1:0] skid_data;

  mux_skid_buf #(.P_W(PL_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .load      (accept && !out_free),
    .load_data (in_pl),
    .unload    (out_free && skid_valid),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  // Skid content is older than anything upstream, so it always drains first.
  assign in_ready = !skid_valid && !flush;
  assign load_out = out_free && (skid_valid || accept);
  assign load_pl  = skid_valid ? skid_data : in_pl;
`else
  assign in_ready = !flush && out_free;
  assign load_out = accept;
  assign load_pl  = in_pl;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      sel_err   <= SEL_ERR_NONE;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_out) begin
      out_valid                    <= 1'b1;
      {sel_err, out_sel, out_data} <= load_pl;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Scoreboard bench for mux_pipe_n: a 4-input and a 5-input instance, directed beats with
// hand-computed expectations queued at issue and checked by per-instance monitors.
module tb_mux_pipe_n;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;

  logic [127:0] in_data4;
  logic [1:0]   sel4 = '0;
  logic         iv4 = 1'b0;
  logic         ir4, err4, ov4;
  logic [31:0]  od4;
  logic [1:0]   os4;

  logic [159:0] in_data5;
  logic [2:0]   sel5 = '0;
  logic         iv5 = 1'b0;
  logic         ir5, err5, ov5;
  logic [31:0]  od5;
  logic [2:0]   os5;

  exp_t q4[$];
  exp_t q5[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .sel(sel4), .in_valid(iv4), .in_ready(ir4),
    .flush(flush), .out_data(od4), .out_sel(os4), .sel_err(err4), .out_valid(ov4),
    .out_ready(out_ready)
  );

  mux_pipe_n #(.WIDTH(32), .NUM_IN(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .sel(sel5), .in_valid(iv5), .in_ready(ir5),
    .flush(flush), .out_data(od5), .out_sel(os5), .sel_err(err5), .out_valid(ov5),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [31:0] d, input logic [3:0] s, input logic e);
    exp_t x;
    x.d = d; x.s = s; x.e = e;
    q4.push_back(x);
  endtask

  task automatic push5(input logic [31:0] d, input logic [3:0] s, input logic e);
    exp_t x;
    x.d = d; x.s = s; x.e = e;
    q5.push_back(x);
  endtask

  // A beat counts as delivered when valid and ready meet at an edge without a flush.
  always @(negedge clk) begin
    if (!rst && ov4 && out_ready && !flush) begin
      exp_t e;
      n_vec++;
      if (q4.size() == 0) begin
        n_err++;
        $display("FAIL mon4_extra: got beat data 0x%08h sel %0d, want no beat", od4, os4);
      end else begin
        e = q4.pop_front();
        if (od4 !== e.d || os4 !== e.s[1:0] || err4 !== e.e) begin
          n_err++;
          $display("FAIL mon4_beat: got data 0x%08h sel %0d err %0b, want data 0x%08h sel %0d err %0b",
                   od4, os4, err4, e.d, e.s, e.e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov5 && out_ready && !flush) begin
      exp_t e;
      n_vec++;
      if (q5.size() == 0) begin
        n_err++;
        $display("FAIL mon5_extra: got beat data 0x%08h sel %0d, want no beat", od5, os5);
      end else begin
        e = q5.pop_front();
        if (od5 !== e.d || os5 !== e.s[2:0] || err5 !== e.e) begin
          n_err++;
          $display("FAIL mon5_beat: got data 0x%08h sel %0d err %0b, want data 0x%08h sel %0d err %0b",
                   od5, os5, err5, e.d, e.s, e.e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0]  t5_sel [5];
    logic [31:0] t5_dat [5];
    logic        t5_err [5];
    logic        pat [4];
    logic        acc;
    int          c;

    in_data4 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    in_data5 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hC0DE_0000};

    // reset held two edges with a beat offered
    rst = 1'b1; iv4 = 1'b1; sel4 = 2'd2; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_out_valid", 32'(ov4), 0);
      chk("rst_out_data", od4, 0);
      chk("rst_out_sel", 32'(os4), 0);
      chk("rst_sel_err", 32'(err4), 0);
    end

    // basic select, then drain keeps data
    rst = 1'b0;
    push4(32'h2222_2222, 4'd2, 1'b0);
    step();
    chk("basic_valid", 32'(ov4), 1);
    chk("basic_data", od4, 32'h2222_2222);
    chk("basic_sel", 32'(os4), 2);
    iv4 = 1'b0;
    step();
    chk("drain_valid", 32'(ov4), 0);
    chk("drain_data_kept", od4, 32'h2222_2222);

    // back-pressure: hold three edges, then drain+accept with no bubble
    iv4 = 1'b1; sel4 = 2'd1; out_ready = 1'b0;
    push4(32'h1111_1111, 4'd1, 1'b0);
    #1;
    chk("bp_in_ready_empty", 32'(ir4), 1);
    step();
    iv4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_valid", 32'(ov4), 1);
      chk("hold_data", od4, 32'h1111_1111);
      chk("hold_sel", 32'(os4), 1);
`ifdef MUX_PIPE_SKID_BUF_EN
      chk("hold_in_ready_skid", 32'(ir4), 1);
`else
      chk("hold_in_ready", 32'(ir4), 0);
`endif
      step();
    end
    out_ready = 1'b1; iv4 = 1'b1; sel4 = 2'd3;
    push4(32'h3333_3333, 4'd3, 1'b0);
    #1;
    chk("release_in_ready", 32'(ir4), 1);
    step();
    chk("nobubble_valid", 32'(ov4), 1);
    chk("nobubble_data", od4, 32'h3333_3333);
    iv4 = 1'b0;
    step();
    chk("post_drain_valid", 32'(ov4), 0);

    // flush of a held beat with a competing incoming beat
    iv4 = 1'b1; sel4 = 2'd1; out_ready = 1'b0;
    step();
    iv4 = 1'b0;
    chk("flush_pre_valid", 32'(ov4), 1);
    flush = 1'b1; iv4 = 1'b1; sel4 = 2'd0;
    #1;
    chk("flush_in_ready", 32'(ir4), 0);
    step();
    flush = 1'b0; iv4 = 1'b0;
    chk("flush_valid", 32'(ov4), 0);
    step();
    chk("flush_no_capture", 32'(ov4), 0);

    // flush coinciding with out_ready still drops the held beat
    iv4 = 1'b1; sel4 = 2'd2; out_ready = 1'b0;
    step();
    iv4 = 1'b0;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready_valid", 32'(ov4), 0);

    // illegal and boundary selects on the 5-input instance
    t5_sel = '{3'd6, 3'd4, 3'd5, 3'd0, 3'd7};
    t5_dat = '{32'h0, 32'h4444_4444, 32'h0, 32'hC0DE_0000, 32'h0};
    t5_err = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel5 = t5_sel[i]; iv5 = 1'b1;
      push5(t5_dat[i], {1'b0, t5_sel[i]}, t5_err[i]);
      step();
      if (i == 0) begin
        chk("illegal_valid", 32'(ov5), 1);
        chk("illegal_data", od5, 0);
        chk("illegal_err", 32'(err5), 1);
      end else if (i == 1) begin
        chk("legal_after_err", 32'(err5), 0);
        chk("legal_data", od5, 32'h4444_4444);
      end
    end
    iv5 = 1'b0;
    step();
    chk("n5_drain_valid", 32'(ov5), 0);

    // stream sel 0..3 with out_ready 1,0,1,1 per cycle
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    c = 0;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i); iv4 = 1'b1;
      push4(32'(i) * 32'h1111_1111, 4'(i), 1'b0);
      acc = 1'b0;
      while (!acc && c < 40) begin
        out_ready = (c < 4) ? pat[c] : 1'b1;
        @(negedge clk);
        acc = ir4;
        step();
        c++;
      end
      if (!acc) begin
        n_vec++; n_err++;
        $display("FAIL stream_timeout: got no accept for beat %0d, want accept", i);
      end
    end
    iv4 = 1'b0; out_ready = 1'b1;
    repeat (3) step();

`ifdef MUX_PIPE_SKID_BUF_EN
    // in_ready must not move when out_ready changes within a cycle
    iv4 = 1'b1; sel4 = 2'd2; out_ready = 1'b0;
    push4(32'h2222_2222, 4'd2, 1'b0);
    step();
    iv4 = 1'b0;
    #1;
    chk("skid_ir_ready_low", 32'(ir4), 1);
    out_ready = 1'b1;
    #1;
    chk("skid_ir_ready_high", 32'(ir4), 1);
    out_ready = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (3) step();
`endif

    chk("q4_empty", 32'(q4.size()), 0);
    chk("q5_empty", 32'(q5.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
